// File: rtl/tag_anc_pkg.sv
// -----------------------------------------------------------------------------
// tag_anc_pkg
//   Definitions shared by the tag RX chain (mixer, symbol integrator):
//   - integ_state_t : integrator control states (IDLE / ALIGN / ACCUM)
//   - TAG_NSIG_DEFAULT / TAG_NSYMB_DEFAULT : default symbol / frame geometry
//   - sat_add() : signed add with clamping to an arbitrary width (<= 63 bits),
//     used by the accumulator when TAG_SYMB_INTEG_SAT_EN is defined.
// -----------------------------------------------------------------------------
package tag_anc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_ACCUM = 2'd2
    } integ_state_t;

    localparam int TAG_NSIG_DEFAULT  = 4096;
    localparam int TAG_NSYMB_DEFAULT = 256;

    typedef struct packed {
        logic signed [63:0] sum;
        logic               clamped;
    } sat_res_t;

    // Adds two sign-extended operands and clamps the result to the signed
    // range of 'width' bits. The 65-bit intermediate cannot overflow for any
    // width <= 63, so the range test is exact.
    function automatic sat_res_t sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int unsigned        width
    );
        logic signed [64:0] full;
        logic signed [64:0] hi;
        logic signed [64:0] lo;
        sat_res_t           res;
        full        = $signed({a[63], a}) + $signed({b[63], b});
        hi          = (65'sd1 <<< (width - 1)) - 65'sd1;
        lo          = -(65'sd1 <<< (width - 1));
        res.sum     = full[63:0];
        res.clamped = 1'b0;
        if (full > hi) begin
            res.sum     = hi[63:0];
            res.clamped = 1'b1;
        end else if (full < lo) begin
            res.sum     = lo[63:0];
            res.clamped = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/tag_symb_integrator_acc.sv
// -----------------------------------------------------------------------------
// tag_symb_acc
//   Single-lane integrate-and-dump accumulator.
//   Build option: TAG_SYMB_INTEG_SAT_EN -> saturating add, else wrap-around.
//
//   clk, reset (async, active-low), srst (sync, active-high)
//   add     : accept 'sample' this cycle
//   dump    : with add, the sample closes the symbol; acc restarts from 0
//   sample  : signed input sample (DATA_WIDTH)
//   sum     : acc + sample (combinational), the value loaded on dump
//   clamp   : high when an accepted add saturated (always 0 without the macro)
// -----------------------------------------------------------------------------
module tag_symb_acc
    import tag_anc_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         srst,
    input  logic                         add,
    input  logic                         dump,
    input  logic signed [DATA_WIDTH-1:0] sample,
    output logic signed [ACC_WIDTH-1:0]  sum,
    output logic                         clamp
);

    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] sample_ext;

    assign sample_ext = ACC_WIDTH'(sample);

`ifdef TAG_SYMB_INTEG_SAT_EN
    sat_res_t res;
    logic     unused_sum_hi;

    always_comb begin
        res = sat_add(64'(acc), 64'(sample_ext), ACC_WIDTH);
    end

    // After clamping, the bits above ACC_WIDTH are pure sign copies.
    assign unused_sum_hi = ^res.sum[63:ACC_WIDTH];
    assign sum           = res.sum[ACC_WIDTH-1:0];
    assign clamp         = add && res.clamped;
`else
    assign sum   = acc + sample_ext;
    assign clamp = 1'b0;
`endif

    // ---- accumulator register ----
    // On the symbol-closing sample the full sum leaves through 'sum' and the
    // accumulator restarts at zero, so the next sample lands in a fresh symbol.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else if (srst) begin
            acc <= '0;
        end else if (add) begin
            acc <= dump ? '0 : sum;
        end
    end

endmodule

// File: rtl/tag_symb_integrator.sv
// -----------------------------------------------------------------------------
// tag_symb_integrator
//   Integrate-and-dump of the de-rotated baseband I/Q stream: NSIG samples per
//   symbol, NSYMB symbols per frame, frames back to back. After the mixer
//   reports sync_ready, ALIGN_OFFSET accepted samples are discarded to absorb
//   upstream latency; the next accepted sample starts symbol 0.
//   Build option: TAG_SYMB_INTEG_SAT_EN -> saturating accumulation with a
//   sticky overflow flag; otherwise wrap-around and overflow tied low.
//
//   clk, reset (async, active-low), srst (sync, active-high, same effect)
//   sync_ready                     : upstream NCO aligned (sampled in IDLE only)
//   in_i, in_q, in_tvalid, in_tlast, in_tready : input stream (tlast ignored)
//   out_i, out_q, out_symb, out_tvalid, out_tlast, out_tready : per-symbol sums
//   overflow                       : sticky saturation flag
// -----------------------------------------------------------------------------
module tag_symb_integrator
    import tag_anc_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int ACC_WIDTH    = 32,
    parameter int NSIG_WIDTH   = 24,
    parameter int NSIG         = TAG_NSIG_DEFAULT,
    parameter int NSYMB_WIDTH  = 16,
    parameter int NSYMB        = TAG_NSYMB_DEFAULT,
    parameter int ALIGN_OFFSET = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          srst,
    input  logic                          sync_ready,
    input  logic signed [DATA_WIDTH-1:0]  in_i,
    input  logic signed [DATA_WIDTH-1:0]  in_q,
    input  logic                          in_tvalid,
    input  logic                          in_tlast,
    output logic                          in_tready,
    output logic signed [ACC_WIDTH-1:0]   out_i,
    output logic signed [ACC_WIDTH-1:0]   out_q,
    output logic [NSYMB_WIDTH-1:0]        out_symb,
    output logic                          out_tvalid,
    output logic                          out_tlast,
    input  logic                          out_tready,
    output logic                          overflow
);

    localparam int ALIGN_CW = (ALIGN_OFFSET > 1) ? $clog2(ALIGN_OFFSET) : 1;
    localparam logic [NSIG_WIDTH-1:0]  SAMPLE_LAST = NSIG_WIDTH'(NSIG - 1);
    localparam logic [NSYMB_WIDTH-1:0] SYMB_LAST   = NSYMB_WIDTH'(NSYMB - 1);
    localparam logic [ALIGN_CW-1:0]    ALIGN_LAST  =
        ALIGN_CW'((ALIGN_OFFSET > 0) ? ALIGN_OFFSET - 1 : 0);

    integ_state_t                state;
    integ_state_t                state_nxt;
    logic [NSIG_WIDTH-1:0]       sample_cnt;
    logic [NSYMB_WIDTH-1:0]      symb_cnt;
    logic [ALIGN_CW-1:0]         align_cnt;
    logic                        closing;
    logic                        acc_add;
    logic                        symb_dump;
    logic signed [ACC_WIDTH-1:0] sum_i;
    logic signed [ACC_WIDTH-1:0] sum_q;
    logic                        clamp_i;
    logic                        clamp_q;
    logic                        unused_tlast;

    // Symbol framing is purely count-based.
    assign unused_tlast = in_tlast;

    assign closing   = (sample_cnt == SAMPLE_LAST);
    assign acc_add   = (state == ST_ACCUM) && in_tvalid && in_tready;
    assign symb_dump = acc_add && closing;

    // ---- control: next state and input ready ----
    // Only the symbol-closing sample can stall: it needs the output register,
    // which is busy while a previous result waits for out_tready.
    always_comb begin
        state_nxt = state;
        in_tready = 1'b1;
        case (state)
            ST_IDLE: begin
                if (sync_ready) begin
                    state_nxt = (ALIGN_OFFSET == 0) ? ST_ACCUM : ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                if (in_tvalid && (align_cnt == ALIGN_LAST)) begin
                    state_nxt = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                in_tready = !(closing && out_tvalid && !out_tready);
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else if (srst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- control: alignment, sample and symbol counters ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            align_cnt  <= '0;
            sample_cnt <= '0;
            symb_cnt   <= '0;
        end else if (srst) begin
            align_cnt  <= '0;
            sample_cnt <= '0;
            symb_cnt   <= '0;
        end else begin
            if ((state == ST_ALIGN) && in_tvalid) begin
                align_cnt <= align_cnt + 1'b1;
            end
            if (acc_add) begin
                sample_cnt <= closing ? '0 : sample_cnt + 1'b1;
            end
            if (symb_dump) begin
                symb_cnt <= (symb_cnt == SYMB_LAST) ? '0 : symb_cnt + 1'b1;
            end
        end
    end

    // ---- datapath: per-lane accumulators ----
    tag_symb_acc #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_acc_i (
        .clk    (clk),
        .reset  (reset),
        .srst   (srst),
        .add    (acc_add),
        .dump   (symb_dump),
        .sample (in_i),
        .sum    (sum_i),
        .clamp  (clamp_i)
    );

    tag_symb_acc #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_acc_q (
        .clk    (clk),
        .reset  (reset),
        .srst   (srst),
        .add    (acc_add),
        .dump   (symb_dump),
        .sample (in_q),
        .sum    (sum_q),
        .clamp  (clamp_q)
    );

    // ---- output register (one entry) ----
    // A load can only happen when the register is empty or being drained this
    // cycle (in_tready guarantees it), so a pending result is never lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_i      <= '0;
            out_q      <= '0;
            out_symb   <= '0;
            out_tlast  <= 1'b0;
            out_tvalid <= 1'b0;
        end else if (srst) begin
            out_i      <= '0;
            out_q      <= '0;
            out_symb   <= '0;
            out_tlast  <= 1'b0;
            out_tvalid <= 1'b0;
        end else if (symb_dump) begin
            out_i      <= sum_i;
            out_q      <= sum_q;
            out_symb   <= symb_cnt;
            out_tlast  <= (symb_cnt == SYMB_LAST);
            out_tvalid <= 1'b1;
        end else if (out_tready) begin
            out_tvalid <= 1'b0;
        end
    end

`ifdef TAG_SYMB_INTEG_SAT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (srst) begin
            overflow <= 1'b0;
        end else if (clamp_i || clamp_q) begin
            overflow <= 1'b1;
        end
    end
`else
    logic unused_clamp;
    assign unused_clamp = clamp_i | clamp_q;
    assign overflow     = 1'b0;
`endif

endmodule

// File: tb/tb_tag_symb_integrator.sv
module tb_tag_symb_integrator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic srst;

    // main instance: NSIG=4, NSYMB=3, ALIGN_OFFSET=2, ACC_WIDTH=32
    logic               sync_ready, in_tvalid, in_tlast, in_tready;
    logic signed [15:0] in_i, in_q;
    logic signed [31:0] out_i, out_q;
    logic [15:0]        out_symb;
    logic               out_tvalid, out_tlast, out_tready, overflow;

    // saturation instance: NSIG=8, ACC_WIDTH=18, ALIGN_OFFSET=0
    logic               s_sync, s_in_tvalid, s_in_tready;
    logic signed [15:0] s_in_i, s_in_q;
    logic signed [17:0] s_out_i, s_out_q;
    logic [15:0]        s_out_symb;
    logic               s_out_tvalid, s_out_tlast, s_out_tready, s_overflow;

    // single-sample instance: NSIG=1, NSYMB=1, ALIGN_OFFSET=0
    logic               o_sync, o_in_tvalid, o_in_tready;
    logic signed [15:0] o_in_i, o_in_q;
    logic signed [31:0] o_out_i, o_out_q;
    logic [15:0]        o_out_symb;
    logic               o_out_tvalid, o_out_tlast, o_out_tready, o_overflow;

    tag_symb_integrator #(
        .DATA_WIDTH(16), .ACC_WIDTH(32), .NSIG_WIDTH(24), .NSIG(4),
        .NSYMB_WIDTH(16), .NSYMB(3), .ALIGN_OFFSET(2)
    ) u_main (
        .clk(clk), .reset(reset), .srst(srst), .sync_ready(sync_ready),
        .in_i(in_i), .in_q(in_q), .in_tvalid(in_tvalid), .in_tlast(in_tlast),
        .in_tready(in_tready), .out_i(out_i), .out_q(out_q), .out_symb(out_symb),
        .out_tvalid(out_tvalid), .out_tlast(out_tlast), .out_tready(out_tready),
        .overflow(overflow)
    );

    tag_symb_integrator #(
        .DATA_WIDTH(16), .ACC_WIDTH(18), .NSIG_WIDTH(24), .NSIG(8),
        .NSYMB_WIDTH(16), .NSYMB(2), .ALIGN_OFFSET(0)
    ) u_sat (
        .clk(clk), .reset(reset), .srst(srst), .sync_ready(s_sync),
        .in_i(s_in_i), .in_q(s_in_q), .in_tvalid(s_in_tvalid), .in_tlast(1'b0),
        .in_tready(s_in_tready), .out_i(s_out_i), .out_q(s_out_q),
        .out_symb(s_out_symb), .out_tvalid(s_out_tvalid), .out_tlast(s_out_tlast),
        .out_tready(s_out_tready), .overflow(s_overflow)
    );

    tag_symb_integrator #(
        .DATA_WIDTH(16), .ACC_WIDTH(32), .NSIG_WIDTH(24), .NSIG(1),
        .NSYMB_WIDTH(16), .NSYMB(1), .ALIGN_OFFSET(0)
    ) u_one (
        .clk(clk), .reset(reset), .srst(srst), .sync_ready(o_sync),
        .in_i(o_in_i), .in_q(o_in_q), .in_tvalid(o_in_tvalid), .in_tlast(1'b0),
        .in_tready(o_in_tready), .out_i(o_out_i), .out_q(o_out_q),
        .out_symb(o_out_symb), .out_tvalid(o_out_tvalid), .out_tlast(o_out_tlast),
        .out_tready(o_out_tready), .overflow(o_overflow)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Main-instance output capture: handshakes seen at the falling edge.
    typedef struct {
        longint i;
        longint q;
        int     symb;
        bit     last;
    } res_t;
    res_t mq[$];

    always @(negedge clk) begin
        if (out_tvalid && out_tready)
            mq.push_back('{i: out_i, q: out_q, symb: int'(out_symb), last: out_tlast});
    end

    task automatic pop_chk(input string tag, input longint ei, input longint eq,
                           input int es, input bit el);
        res_t r;
        chk({tag, "_present"}, mq.size() > 0, 1);
        if (mq.size() > 0) begin
            r = mq.pop_front();
            chk({tag, "_i"}, r.i, ei);
            chk({tag, "_q"}, r.q, eq);
            chk({tag, "_symb"}, r.symb, es);
            chk({tag, "_tlast"}, r.last, el);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lock();
        sync_ready = 1'b1;
        tick();
        sync_ready = 1'b0;
    endtask

    task automatic soft_lock();
        srst = 1'b1;
        tick();
        srst = 1'b0;
        lock();
    endtask

    // Present one sample on the main instance and hold it until accepted.
    task automatic send(input int vi, input int vq);
        bit acc;
        in_i      = 16'(vi);
        in_q      = 16'(vq);
        in_tvalid = 1'b1;
        acc       = 1'b0;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = in_tready;
            @(posedge clk);
            #1;
        end
        chk("send_accept", acc, 1);
    endtask

    initial begin
        int  idx;
        int  stall_cnt;
        int  stall_idx;
        int  stable_bad;
        bit  acc;
        int  vals[3];

        reset = 1'b0; srst = 1'b0;
        sync_ready = 1'b0; in_tvalid = 1'b0; in_tlast = 1'b0;
        in_i = '0; in_q = '0; out_tready = 1'b1;
        s_sync = 1'b0; s_in_tvalid = 1'b0; s_in_i = '0; s_in_q = '0; s_out_tready = 1'b1;
        o_sync = 1'b0; o_in_tvalid = 1'b0; o_in_i = '0; o_in_q = '0; o_out_tready = 1'b1;

        // ---------------- reset state ----------------
        repeat (2) tick();
        chk("rst_out_i", out_i, 0);
        chk("rst_out_q", out_q, 0);
        chk("rst_out_symb", out_symb, 0);
        chk("rst_out_tvalid", out_tvalid, 0);
        chk("rst_out_tlast", out_tlast, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_in_tready", in_tready, 1);
        reset = 1'b1;
        tick();

        // ---------------- alignment, sums, latency ----------------
        send(100, 100);           // dropped: still IDLE
        send(100, 100);
        lock();
        for (int v = 1; v <= 14; v++) begin
            send(v, -1);
            chk($sformatf("lat_v%0d", v), out_tvalid, (v >= 3 && (v - 2) % 4 == 0));
        end
        in_tvalid = 1'b0;
        repeat (3) tick();
        pop_chk("t1_s0", 18, -4, 0, 0);
        pop_chk("t1_s1", 34, -4, 1, 0);
        pop_chk("t1_s2", 50, -4, 2, 1);
        chk("t1_extra", mq.size(), 0);

        // ---------------- backpressure ----------------
        soft_lock();
        in_tvalid  = 1'b1;
        idx        = 0;
        stall_cnt  = 0;
        stall_idx  = -1;
        stable_bad = 0;
        for (int c = 0; c < 40 && idx < 10; c++) begin
            out_tready = (c >= 14);
            in_i = 16'(idx + 1);
            in_q = 16'(-(idx + 1));
            @(negedge clk);
            if (!in_tready) begin
                stall_cnt++;
                stall_idx = idx;
            end
            if (out_tvalid && !out_tready && (out_i != 18 || out_symb != 0))
                stable_bad++;
            acc = in_tready;
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        in_tvalid  = 1'b0;
        out_tready = 1'b1;
        repeat (3) tick();
        chk("bp_all_fed", idx, 10);
        chk("bp_stall_cycles", stall_cnt, 5);
        chk("bp_stall_sample", stall_idx, 9);
        chk("bp_hold_stable", stable_bad, 0);
        pop_chk("t2_s0", 18, -18, 0, 0);
        pop_chk("t2_s1", 34, -34, 1, 0);
        chk("t2_extra", mq.size(), 0);

        // ---------------- symbol index wrap ----------------
        soft_lock();
        repeat (2) send(9, 9);
        repeat (28) send(2, 0);
        in_tvalid = 1'b0;
        repeat (3) tick();
        for (int k = 0; k < 7; k++)
            pop_chk($sformatf("wrap%0d", k), 8, 0, k % 3, (k % 3) == 2);
        chk("wrap_extra", mq.size(), 0);

        // ---------------- mid-symbol reset ----------------
        soft_lock();
        out_tready = 1'b0;
        repeat (2) send(1, 1);
        repeat (6) send(3, 3);    // symbol 0 pending, 2 samples into symbol 1
        in_tvalid = 1'b0;
        chk("mr_pending", out_tvalid, 1);
        reset = 1'b0;
        #2;
        chk("mr_out_tvalid", out_tvalid, 0);
        chk("mr_out_i", out_i, 0);
        chk("mr_out_q", out_q, 0);
        chk("mr_out_symb", out_symb, 0);
        chk("mr_out_tlast", out_tlast, 0);
        tick();
        reset = 1'b1;
        out_tready = 1'b1;
        tick();
        repeat (2) send(50, 50);  // dropped: IDLE until relock
        lock();
        repeat (2) send(7, 7);
        repeat (4) send(5, -5);
        in_tvalid = 1'b0;
        repeat (3) tick();
        pop_chk("t4_relock", 20, -20, 0, 0);
        chk("t4_extra", mq.size(), 0);
        chk("main_overflow", overflow, 0);

        // ---------------- NSIG=1, NSYMB=1 ----------------
        o_sync = 1'b1;
        tick();
        o_sync = 1'b0;
        vals = '{5, -7, 32767};
        foreach (vals[k]) begin
            o_in_i = 16'(vals[k]);
            o_in_q = 16'(-vals[k]);
            o_in_tvalid = 1'b1;
            chk($sformatf("one_ready%0d", k), o_in_tready, 1);
            tick();
            chk($sformatf("one_valid%0d", k), o_out_tvalid, 1);
            chk($sformatf("one_i%0d", k), o_out_i, vals[k]);
            chk($sformatf("one_q%0d", k), o_out_q, -vals[k]);
            chk($sformatf("one_symb%0d", k), o_out_symb, 0);
            chk($sformatf("one_tlast%0d", k), o_out_tlast, 1);
        end
        o_in_tvalid = 1'b0;
        tick();
        chk("one_idle_valid", o_out_tvalid, 0);

        // ---------------- saturation / wrap at ACC_WIDTH=18 ----------------
        s_sync = 1'b1;
        tick();
        s_sync = 1'b0;
        s_in_i = 16'sd32767;
        s_in_q = -16'sd32768;
        s_in_tvalid = 1'b1;
        repeat (7) tick();
        chk("sat_not_yet", s_out_tvalid, 0);
        tick();
        s_in_tvalid = 1'b0;
        chk("sat_valid", s_out_tvalid, 1);
`ifdef TAG_SYMB_INTEG_SAT_EN
        chk("sat_out_i", s_out_i, 131071);
        chk("sat_out_q", s_out_q, -131072);
        chk("sat_overflow", s_overflow, 1);
`else
        chk("wrap_out_i", s_out_i, -8);
        chk("wrap_out_q", s_out_q, 0);
        chk("wrap_overflow", s_overflow, 0);
`endif
        srst = 1'b1;
        tick();
        srst = 1'b0;
        chk("sat_srst_overflow", s_overflow, 0);
        chk("sat_srst_valid", s_out_tvalid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
